// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with clear engine (optional REGFILE_BYPASS_EN forwarding)
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [N_RD*ADDR_W-1:0]   raddr,
    output logic [N_RD*DATA_W-1:0]   rdata,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                wr_zero_blocked;

    // Entry 0 is never written by the datapath when it is hardwired to zero.
    assign wr_zero_blocked = (ZERO_REG != 0) && (waddr == '0);

    // Next-state and memory write-port selection: the clear engine owns the port while active.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    // Clear wins over a simultaneous write.
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (we && !wr_zero_blocked) begin
                    mem_we = 1'b1;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Control state register; reset always (re)starts a full clear from entry 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage array; the reset edge itself leaves entries untouched.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign busy = (state_q == ST_CLEAR);

    // Independent combinational read ports.
    for (genvar g = 0; g < N_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_val;

        assign rd_addr = raddr[g*ADDR_W +: ADDR_W];

        // Read mux: array value, optional forwarding, hardwired zero, then forced zero while clearing.
        always_comb begin
            rd_val = mem_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if ((state_q == ST_IDLE) && we && !clr_req && (waddr == rd_addr)) begin
                rd_val = wdata;
            end
`endif
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_val = '0;
            end
            if (state_q == ST_CLEAR) begin
                rd_val = '0;
            end
        end

        assign rdata[g*DATA_W +: DATA_W] = rd_val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [63:0] rdata_nz;
    logic        clr_req;
    logic        busy;
    logic        busy_nz;

    int total = 0;
    int bad   = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rdata   (rdata),
        .clr_req (clr_req),
        .busy    (busy)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(0)) u_dut_nz (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rdata   (rdata_nz),
        .clr_req (clr_req),
        .busy    (busy_nz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    // Counts edges until busy drops; clr_req pulsed mid-clear must not restart it.
    task automatic count_busy(input string tag, input logic keep_we);
        int n = 0;
        while (busy && n < 100) begin
            clr_req = (n == 5);
            step();
            n++;
        end
        clr_req = 1'b0;
        if (!keep_we) we = 1'b0;
        we = 1'b0;
        chk(tag, 32'(n), 32'd32);
        chk({tag, "_nz"}, 32'(busy_nz), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr   = '0;
        clr_req = 1'b0;

        // 1: reset and initial clear
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        set_rd(5'd3, 5'd17);
        chk("rst_rd0_busy", rdata[31:0], 32'h0);
        chk("rst_rd1_busy", rdata[63:32], 32'h0);
        count_busy("rst_clear_len", 1'b0);
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            chk("rst_zero_p0", rdata[31:0], 32'h0);
            chk("rst_zero_p1", rdata[63:32], 32'h0);
        end

        // 2: write / read
        wr(5'd5, 32'hDEADBEEF);
        wr(5'd31, 32'h12345678);
        set_rd(5'd5, 5'd31);
        chk("wr_r5", rdata[31:0], 32'hDEADBEEF);
        chk("wr_r31", rdata[63:32], 32'h12345678);
        set_rd(5'd5, 5'd5);
        chk("same_p0", rdata[31:0], 32'hDEADBEEF);
        chk("same_p1", rdata[63:32], 32'hDEADBEEF);

        // 3: hardwired zero entry
        wr(5'd0, 32'hFFFFFFFF);
        set_rd(5'd0, 5'd0);
        chk("zr_p0", rdata[31:0], 32'h0);
        chk("zr_p1", rdata[63:32], 32'h0);
        chk("nz_p0", rdata_nz[31:0], 32'hFFFFFFFF);
        chk("nz_p1", rdata_nz[63:32], 32'hFFFFFFFF);

        // 4: clear beats write; writes during clear dropped
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
        set_rd(5'd7, 5'd30);
        chk("fill_r7", rdata[31:0], 32'h07070707);
        chk("fill_r30", rdata[63:32], 32'h1E1E1E1E);
        clr_req = 1'b1;
        we      = 1'b1;
        waddr   = 5'd7;
        wdata   = 32'hA5A5A5A5;
        step();
        clr_req = 1'b0;
        waddr   = 5'd3;
        wdata   = 32'h00001111;
        #1;
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_rd_busy", rdata[31:0], 32'h0);
        count_busy("clr_len", 1'b1);
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            chk("clr_zero_p0", rdata[31:0], 32'h0);
            chk("clr_zero_p1", rdata[63:32], 32'h0);
            chk("clr_zero_nz", rdata_nz[31:0], 32'h0);
        end

        // 5: reset on clear edge 10 restarts a full clear
        wr(5'd12, 32'hCAFE0012);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        reset_n = 1'b0;
        step();
        chk("midrst_busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        count_busy("midrst_len", 1'b0);
        set_rd(5'd12, 5'd31);
        chk("midrst_r12", rdata[31:0], 32'h0);
        chk("midrst_r31", rdata[63:32], 32'h0);

        // 6: same-cycle read of the written address
        wr(5'd9, 32'h11112222);
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'h0BADF00D;
        set_rd(5'd9, 5'd4);
`ifdef REGFILE_BYPASS_EN
        chk("byp_same", rdata[31:0], 32'h0BADF00D);
`else
        chk("byp_same", rdata[31:0], 32'h11112222);
`endif
        step();
        we = 1'b0;
        #1;
        chk("byp_next", rdata[31:0], 32'h0BADF00D);
        chk("byp_next_nz", rdata_nz[31:0], 32'h0BADF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
